// File: rtl/combolock_input_cond.sv
`default_nettype none
// ============================================================================
// Module   : combolock_input_cond
// Purpose  : Input conditioner in front of the combination-lock core.
//            Synchronises and debounces the raw enable, submit and code
//            switches. Each accepted submit press becomes a single-cycle
//            strobe, and the code present at that moment is captured and
//            held for the core to compare.
// Ports    : clk              - system clock
//            rst_n            - asynchronous active-low reset
//            sw_en_raw        - raw lock-enable switch (asynchronous)
//            sw_submit_raw    - raw submit switch/button (asynchronous)
//            sw_code_raw      - raw passcode switches (asynchronous)
//            en               - debounced enable level
//            submit_pulse     - one-cycle strobe per accepted submit press
//            passcode_attempt - code captured with the strobe, held until
//                               the next strobe
//            code_live        - debounced code switches, continuous
//            glitch_cnt       - (COMBOLOCK_GLITCH_CNT_EN only) saturating
//                               count of cycles in which at least one
//                               debouncer discarded a pending change
// Options  : define COMBOLOCK_GLITCH_CNT_EN to add glitch_cnt and its logic.
// Revision : 1.0 - initial release
// ============================================================================
module combolock_input_cond #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter int CODE_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sw_en_raw,
    input  logic              sw_submit_raw,
    input  logic [CODE_W-1:0] sw_code_raw,
    output logic              en,
    output logic              submit_pulse,
    output logic [CODE_W-1:0] passcode_attempt,
    output logic [CODE_W-1:0] code_live
`ifdef COMBOLOCK_GLITCH_CNT_EN
    ,
    output logic [7:0]        glitch_cnt
`endif
);

    // Bit map of the conditioned bus: [0]=enable, [1]=submit, [CODE_W+1:2]=code
    localparam int c_nbits = CODE_W + 2;
    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [c_nbits-1:0] w_raw;
    logic [c_nbits-1:0] w_sync;
    logic [c_nbits-1:0] w_stable;
    logic               w_sub_d;
    logic               w_primed;

    assign w_raw = {sw_code_raw, sw_submit_raw, sw_en_raw};

    // ------------------------------------------------------------------
    // Synchronisers: one SYNC_STAGES-deep chain per bit.
    // A token chain of the same depth marks when the chain output first
    // reflects the real switch level rather than its reset value.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][c_nbits-1:0] r_sync;
    logic [SYNC_STAGES-1:0]              r_prime;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_prime <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], w_raw};
            r_prime <= {r_prime[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_primed = r_prime[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Per-bit debouncers. A change is accepted only after the synchronised
    // level has differed from the stable level for DEBOUNCE_CYCLES
    // consecutive cycles; any return to the stable level restarts the count.
    // ------------------------------------------------------------------
`ifdef COMBOLOCK_GLITCH_CNT_EN
    logic [c_nbits-1:0] w_reject;
`endif

    generate
        for (genvar gi = 0; gi < c_nbits; gi++) begin : g_debounce
            logic [c_cnt_w-1:0] r_cnt;
            logic               r_stb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                    r_stb <= 1'b0;
                end else if (w_sync[gi] != r_stb) begin
                    if (r_cnt == c_cnt_last) begin
                        r_stb <= w_sync[gi];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign w_stable[gi] = r_stb;

`ifdef COMBOLOCK_GLITCH_CNT_EN
            // Pending change abandoned: counter was running and input fell back
            assign w_reject[gi] = (w_sync[gi] == r_stb) && (r_cnt != '0);
`endif
        end
    endgenerate

    assign en        = w_stable[0];
    assign w_sub_d   = w_stable[1];
    assign code_live = w_stable[c_nbits-1:2];

    // ------------------------------------------------------------------
    // Submit strobe FSM. The strobe and the captured code are registered
    // on the same edge, so passcode_attempt is valid with submit_pulse.
    // WAIT_RELEASE only re-arms once the synchroniser is primed and both
    // the debounced and synchronised submit levels are low; a switch held
    // through reset therefore needs a genuine release before it can fire.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_WAIT_RELEASE = 2'd0,
        ST_IDLE         = 2'd1,
        ST_FIRE         = 2'd2
    } state_t;

    state_t r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_WAIT_RELEASE;
            submit_pulse     <= 1'b0;
            passcode_attempt <= '0;
        end else begin
            submit_pulse <= 1'b0;
            case (r_state)
                ST_WAIT_RELEASE: begin
                    if (w_primed && !w_sub_d && !w_sync[1]) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_sub_d) begin
                        if (en) begin
                            r_state          <= ST_FIRE;
                            submit_pulse     <= 1'b1;
                            passcode_attempt <= code_live;
                        end else begin
                            // Press while disabled is swallowed
                            r_state <= ST_WAIT_RELEASE;
                        end
                    end
                end
                ST_FIRE: begin
                    r_state <= ST_WAIT_RELEASE;
                end
                default: begin
                    r_state <= ST_WAIT_RELEASE;
                end
            endcase
        end
    end

`ifdef COMBOLOCK_GLITCH_CNT_EN
    // ------------------------------------------------------------------
    // Glitch counter: one count per cycle with any rejection, saturating.
    // ------------------------------------------------------------------
    logic [7:0] r_glitch_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch_cnt <= 8'h00;
        end else if ((|w_reject) && (r_glitch_cnt != 8'hFF)) begin
            r_glitch_cnt <= r_glitch_cnt + 8'd1;
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_combolock_input_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_combolock_input_cond
// Purpose  : Self-checking bench for combolock_input_cond. A behavioural
//            model built on sample histories (window of consecutive samples,
//            armed/consumed press flag) is compared with the DUT on every
//            falling clock edge; directed scenarios add literal expectations.
// Options  : COMBOLOCK_GLITCH_CNT_EN also checks glitch_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_combolock_input_cond;

    localparam int DEB  = 4;
    localparam int SYNC = 2;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sw_en_raw = 1'b0;
    logic          sw_submit_raw = 1'b0;
    logic [CW-1:0] sw_code_raw = '0;
    logic          en;
    logic          submit_pulse;
    logic [CW-1:0] passcode_attempt;
    logic [CW-1:0] code_live;
`ifdef COMBOLOCK_GLITCH_CNT_EN
    logic [7:0]    glitch_cnt;
`endif

    combolock_input_cond #(
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYNC),
        .CODE_W          (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sw_en_raw        (sw_en_raw),
        .sw_submit_raw    (sw_submit_raw),
        .sw_code_raw      (sw_code_raw),
        .en               (en),
        .submit_pulse     (submit_pulse),
        .passcode_attempt (passcode_attempt),
        .code_live        (code_live)
`ifdef COMBOLOCK_GLITCH_CNT_EN
        ,
        .glitch_cnt       (glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Bit map: [0]=en, [1]=submit, [9:2]=code.
    // raw_h : raw samples per edge (padded with reset zeros)
    // sv_h  : synchronised value seen at each edge (padded with zeros)
    // A bit flips when its last DEB synchronised samples all differ from it.
    // ------------------------------------------------------------------
    logic [9:0] raw_h[$];
    logic [9:0] sv_h[$];
    logic [9:0] m_stable;
    bit         m_armed;
    logic       m_pulse;
    logic [7:0] m_pass;
    int         m_glitch;
    int         m_edges;

    task automatic model_reset();
        raw_h = {};
        sv_h  = {};
        for (int i = 0; i < SYNC; i++) raw_h.push_back(10'd0);
        for (int i = 0; i < DEB + 1; i++) sv_h.push_back(10'd0);
        m_stable = '0;
        m_armed  = 1'b0;
        m_pulse  = 1'b0;
        m_pass   = '0;
        m_glitch = 0;
        m_edges  = 0;
    endtask

    always @(posedge clk) begin : model_step
        logic [9:0] raw;
        logic [9:0] s;
        logic [9:0] prev;
        bit         all_diff;
        if (rst_n) begin
            raw  = {sw_code_raw, sw_submit_raw, sw_en_raw};
            s    = raw_h[raw_h.size() - SYNC];
            prev = sv_h[sv_h.size() - 1];
            m_edges++;

            // Press handling from the levels before this edge
            m_pulse = 1'b0;
            if (m_stable[1]) begin
                if (m_armed) begin
                    m_armed = 1'b0;
                    if (m_stable[0]) begin
                        m_pulse = 1'b1;
                        m_pass  = m_stable[9:2];
                    end
                end
            end else if (!s[1] && m_edges > SYNC) begin
                m_armed = 1'b1;
            end

            // A run of differing samples ended without acceptance
            if ((((prev ^ m_stable) & ~(s ^ m_stable)) != 10'd0) && m_glitch < 255)
                m_glitch++;

            sv_h.push_back(s);
            for (int b = 0; b < 10; b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (sv_h[sv_h.size() - 1 - k][b] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) m_stable[b] = ~m_stable[b];
            end
            raw_h.push_back(raw);
            while (raw_h.size() > 16) void'(raw_h.pop_front());
            while (sv_h.size() > 16) void'(sv_h.pop_front());
        end
    end

    // Compare process: outputs are stable half a cycle after the active edge
    always @(negedge clk) begin
        check("en", {31'd0, en}, {31'd0, m_stable[0]});
        check("code_live", {24'd0, code_live}, {24'd0, m_stable[9:2]});
        check("submit_pulse", {31'd0, submit_pulse}, {31'd0, m_pulse});
        check("passcode_attempt", {24'd0, passcode_attempt}, {24'd0, m_pass});
`ifdef COMBOLOCK_GLITCH_CNT_EN
        check("glitch_cnt", {24'd0, glitch_cnt}, m_glitch);
`endif
        if (submit_pulse) pulse_cnt++;
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive submit high for hi cycles then low for lo cycles
    task automatic press(input int hi, input int lo);
        @(negedge clk);
        sw_submit_raw = 1'b1;
        wait_neg(hi);
        sw_submit_raw = 1'b0;
        wait_neg(lo);
    endtask

    int p0;

    initial begin
        model_reset();
        sw_en_raw = 1'b1;
        do_reset();
        wait_neg(12);

        // --- 1: basic press latency and capture ---
        @(negedge clk);
        sw_code_raw = 8'h49;
        wait_neg(12);
        check("t1_code_live", {24'd0, code_live}, 32'h49);
        check("t1_reset_pass", {24'd0, passcode_attempt}, 32'h0);
        p0 = pulse_cnt;
        @(negedge clk);
        sw_submit_raw = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check("t1_pulse_timing", {31'd0, submit_pulse}, (i == 7) ? 32'd1 : 32'd0);
            if (i == 7) check("t1_pass_at_pulse", {24'd0, passcode_attempt}, 32'h49);
        end
        wait_neg(11);
        sw_submit_raw = 1'b0;
        wait_neg(12);
        check("t1_pulse_count", pulse_cnt - p0, 32'd1);
        check("t1_pass_held", {24'd0, passcode_attempt}, 32'h49);

        // --- 2: short bounce rejected ---
        do_reset();
        wait_neg(12);
        p0 = pulse_cnt;
        press(3, 12);
        check("t2_no_pulse", pulse_cnt - p0, 32'd0);
`ifdef COMBOLOCK_GLITCH_CNT_EN
        check("t2_glitch_cnt", {24'd0, glitch_cnt}, 32'd1);
`endif

        // --- 3: two presses -> two pulses; long hold -> one pulse ---
        p0 = pulse_cnt;
        press(10, 10);
        press(10, 14);
        check("t3_two_presses", pulse_cnt - p0, 32'd2);
        p0 = pulse_cnt;
        press(100, 14);
        check("t3_long_hold", pulse_cnt - p0, 32'd1);

        // --- 4: press while disabled is swallowed ---
        @(negedge clk);
        sw_en_raw = 1'b0;
        wait_neg(12);
        check("t4_en_low", {31'd0, en}, 32'd0);
        p0 = pulse_cnt;
        @(negedge clk);
        sw_submit_raw = 1'b1;
        wait_neg(20);
        sw_en_raw = 1'b1;
        wait_neg(20);
        check("t4_swallowed", pulse_cnt - p0, 32'd0);
        sw_submit_raw = 1'b0;
        wait_neg(12);
        press(20, 14);
        check("t4_after_release", pulse_cnt - p0, 32'd1);

        // --- 5: submit held through reset ---
        @(negedge clk);
        sw_submit_raw = 1'b1;
        do_reset();
        p0 = pulse_cnt;
        wait_neg(30);
        check("t5_held_no_pulse", pulse_cnt - p0, 32'd0);
        sw_submit_raw = 1'b0;
        wait_neg(12);
        press(20, 14);
        check("t5_new_press", pulse_cnt - p0, 32'd1);

        // --- 6: reset in the FIRE cycle ---
        @(negedge clk);
        sw_code_raw = 8'h5A;
        wait_neg(12);
        @(negedge clk);
        sw_submit_raw = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("t6_fire_pulse", {31'd0, submit_pulse}, 32'd1);
        check("t6_fire_pass", {24'd0, passcode_attempt}, 32'h5A);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_async_pulse", {31'd0, submit_pulse}, 32'd0);
        check("t6_async_pass", {24'd0, passcode_attempt}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        p0 = pulse_cnt;
        wait_neg(30);
        check("t6_no_pulse_after", pulse_cnt - p0, 32'd0);
        sw_submit_raw = 1'b0;
        wait_neg(12);

        // --- randomized phase checked by the model every cycle ---
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0)  sw_submit_raw = ~sw_submit_raw;
            if ($urandom_range(0, 29) == 0) sw_en_raw = ~sw_en_raw;
            if ($urandom_range(0, 5) == 0)  sw_code_raw[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        wait_neg(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
